// File: rtl/char_pipe_if.sv
// Pixel request / pixel result bundle between the text-mode scanout and the glyph pipeline.
interface char_pipe_if #(
  parameter int GW   = 16,
  parameter int GH   = 16,
  parameter int CW   = 8,
  parameter int COLW = 12
);
  localparam int XW = (GW > 1) ? $clog2(GW) : 1;
  localparam int YW = (GH > 1) ? $clog2(GH) : 1;

  logic            in_valid;
  logic [CW-1:0]   in_code;
  logic [XW-1:0]   in_x;
  logic [YW-1:0]   in_y;
  logic [COLW-1:0] in_fg;
  logic [COLW-1:0] in_bg;
  logic            in_blink;
  logic            in_cursor;
  logic            out_valid;
  logic            out_pixel;
  logic [COLW-1:0] out_rgb;

  modport master (
    output in_valid, in_code, in_x, in_y, in_fg, in_bg, in_blink, in_cursor,
    input  out_valid, out_pixel, out_rgb
  );
  modport slave (
    input  in_valid, in_code, in_x, in_y, in_fg, in_bg, in_blink, in_cursor,
    output out_valid, out_pixel, out_rgb
  );
endinterface

// File: rtl/char_pipe.sv
// Three-stage glyph pixel pipeline: ROM address issue, ROM wait, pixel/colour select.
// Includes the frame-based blink phase generator.
module char_pipe #(
  parameter int GW           = 16,
  parameter int GH           = 16,
  parameter int CW           = 8,
  parameter int COLW         = 12,
  parameter int BLINK_FRAMES = 32,
  localparam int XW = (GW > 1) ? $clog2(GW) : 1,
  localparam int YW = (GH > 1) ? $clog2(GH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_tick,
  char_pipe_if.slave        pif,
  output logic              rom_en,
  output logic [CW+YW-1:0]  rom_addr,
  input  logic [GW-1:0]     rom_data,
  output logic              blink_phase
);
  localparam int STAGES = 3;
  localparam int BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic [XW-1:0]   x;
    logic [COLW-1:0] fg;
    logic [COLW-1:0] bg;
    logic            blink;
    logic            cursor;
  } side_t;

  logic [STAGES:1]  vld_pipe_q, vld_pipe_d;
  side_t            side1_q, side1_d, side2_q, side2_d;
  logic [CW+YW-1:0] rom_addr_q, rom_addr_d;
  logic             out_pixel_q, out_pixel_d;
  logic [COLW-1:0]  out_rgb_q, out_rgb_d;
  logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic             glyph_bit, pix_bit;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], pif.in_valid};
    rom_addr_d = {pif.in_code, pif.in_y};
    side1_d    = {pif.in_x, pif.in_fg, pif.in_bg, pif.in_blink, pif.in_cursor};
    side2_d    = side1_q;
  end

  // Columns past the glyph width match no index and stay blank.
  always_comb begin
    glyph_bit = 1'b0;
    for (int i = 0; i < GW; i++)
      if (side2_q.x == XW'(i)) glyph_bit = rom_data[GW-1-i];
    if (side2_q.blink && blink_phase_q) glyph_bit = 1'b0;
    pix_bit     = glyph_bit ^ side2_q.cursor;
    out_pixel_d = vld_pipe_q[2] & pix_bit;
    out_rgb_d   = '0;
    if (vld_pipe_q[2]) out_rgb_d = pix_bit ? side2_q.fg : side2_q.bg;
  end

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_tick) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q    <= '0;
      rom_addr_q    <= '0;
      side1_q       <= '0;
      side2_q       <= '0;
      out_pixel_q   <= 1'b0;
      out_rgb_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      vld_pipe_q    <= vld_pipe_d;
      rom_addr_q    <= rom_addr_d;
      side1_q       <= side1_d;
      side2_q       <= side2_d;
      out_pixel_q   <= out_pixel_d;
      out_rgb_q     <= out_rgb_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign rom_en        = vld_pipe_q[1];
  assign rom_addr      = rom_addr_q;
  assign blink_phase   = blink_phase_q;
  assign pif.out_valid = vld_pipe_q[STAGES];
  assign pif.out_pixel = out_pixel_q;
  assign pif.out_rgb   = out_rgb_q;
endmodule

// File: tb/tb_char_pipe.sv
// Randomized + directed bench for char_pipe against a request-level pixel model.
module tb_char_pipe;
  localparam int GW = 16, GH = 16, CW = 8, COLW = 12, BF = 2;

  typedef struct packed {
    logic       v;
    logic [7:0] code;
    logic [3:0] x;
    logic [3:0] y;
    logic [11:0] fg;
    logic [11:0] bg;
    logic       blink;
    logic       cursor;
  } req_t;

  typedef struct packed {
    logic       v;
    logic       pix;
    logic [11:0] rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [15:0] rom_data = '0;
  logic        blink_phase;
  logic [15:0] rom_mem [0:4095];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   ticks   = 0;
  req_t h1 = '0, h2 = '0;

  char_pipe_if #(.GW(GW), .GH(GH), .CW(CW), .COLW(COLW)) pif ();

  char_pipe #(.GW(GW), .GH(GH), .CW(CW), .COLW(COLW), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pif(pif.slave),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic phase_of(input int t);
    return ((t / BF) % 2) == 1;
  endfunction

  // Expected pixel straight from the glyph/blink/cursor rules.
  function automatic exp_t model(input req_t r, input logic ph);
    exp_t e;
    int   b;
    logic [15:0] g;
    e = '0;
    if (!r.v) return e;
    g = rom_mem[{r.code, r.y}];
    b = (int'(r.x) < GW) ? int'((g >> (GW - 1 - int'(r.x))) & 16'h1) : 0;
    if (r.blink && ph) b = 0;
    if (r.cursor) b = 1 - b;
    e.v   = 1'b1;
    e.pix = (b == 1);
    e.rgb = (b == 1) ? r.fg : r.bg;
    return e;
  endfunction

  function automatic req_t mk(input logic [7:0] code, input logic [3:0] x, input logic [3:0] y,
                              input logic [11:0] fg, input logic [11:0] bg,
                              input logic blink, input logic cursor);
    req_t r;
    r = '{v: 1'b1, code: code, x: x, y: y, fg: fg, bg: bg, blink: blink, cursor: cursor};
    return r;
  endfunction

  task automatic drive(input req_t r, input logic tick);
    pif.in_valid  = r.v;
    pif.in_code   = r.code;
    pif.in_x      = r.x;
    pif.in_y      = r.y;
    pif.in_fg     = r.fg;
    pif.in_bg     = r.bg;
    pif.in_blink  = r.blink;
    pif.in_cursor = r.cursor;
    frame_tick    = tick;
  endtask

  // One clock: drive at negedge, let the edge happen, check at next negedge.
  task automatic cycle(input req_t r, input logic tick);
    exp_t e;
    drive(r, tick);
    e = model(h2, phase_of(ticks));
    h2 = h1;
    h1 = r;
    if (tick) ticks++;
    @(posedge clk);
    @(negedge clk);
    check("out_valid", 32'(pif.out_valid), 32'(e.v));
    check("out_pixel", 32'(pif.out_pixel), 32'(e.pix));
    check("out_rgb", 32'(pif.out_rgb), 32'(e.rgb));
    check("rom_en", 32'(rom_en), 32'(r.v));
    if (r.v) check("rom_addr", 32'(rom_addr), 32'({r.code, r.y}));
    check("blink_phase", 32'(blink_phase), 32'(phase_of(ticks)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, 1'b0);
  endtask

  initial begin
    req_t r;
    logic [15:0] pat;
    logic [4:0]  vpat [0:0];
    for (int i = 0; i < 4096; i++) rom_mem[i] = 16'($urandom);
    rom_mem[12'h413] = 16'h8000;
    rom_mem[12'h205] = 16'hA5A5;
    rom_mem[12'h300] = 16'hFFFF;
    rom_mem[12'h310] = 16'h0000;
    drive('0, 1'b0);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(pif.out_valid), 0);
    check("rst_out_pixel", 32'(pif.out_pixel), 0);
    check("rst_out_rgb", 32'(pif.out_rgb), 0);
    check("rst_rom_en", 32'(rom_en), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_blink_phase", 32'(blink_phase), 0);
    rst_n = 1'b1;

    // single pixel, accepted on the first edge after release
    cycle(mk(8'h41, 4'd0, 4'd3, 12'hFFF, 12'h000, 1'b0, 1'b0), 1'b0);
    check("single_addr", 32'(rom_addr), 32'h413);
    idle(1);
    check("single_not_yet", 32'(pif.out_valid), 0);
    idle(1);
    check("single_valid", 32'(pif.out_valid), 1);
    check("single_pixel", 32'(pif.out_pixel), 1);
    check("single_rgb", 32'(pif.out_rgb), 32'hFFF);
    idle(2);

    // streaming a whole row
    for (int x = 0; x < 16; x++) cycle(mk(8'h20, 4'(x), 4'd5, 12'hF00, 12'h00F, 1'b0, 1'b0), 1'b0);
    idle(2);

    // blink: two ticks flip phase, two more restore
    cycle(mk(8'h30, 4'd7, 4'd0, 12'h0F0, 12'h123, 1'b1, 1'b0), 1'b0);
    idle(2);
    check("blink_on_pixel", 32'(pif.out_pixel), 1);
    cycle('0, 1'b1);
    cycle('0, 1'b1);
    check("blink_phase_1", 32'(blink_phase), 1);
    cycle(mk(8'h30, 4'd7, 4'd0, 12'h0F0, 12'h123, 1'b1, 1'b0), 1'b0);
    idle(2);
    check("blink_off_pixel", 32'(pif.out_pixel), 0);
    check("blink_off_rgb", 32'(pif.out_rgb), 32'h123);
    // cursor stays visible during blink-off
    cycle(mk(8'h30, 4'd2, 4'd0, 12'h0F0, 12'h123, 1'b1, 1'b1), 1'b0);
    idle(2);
    check("cursor_blink_pixel", 32'(pif.out_pixel), 1);
    cycle('0, 1'b1);
    cycle('0, 1'b1);
    cycle(mk(8'h30, 4'd7, 4'd0, 12'h0F0, 12'h123, 1'b1, 1'b0), 1'b0);
    idle(2);
    check("blink_restored", 32'(pif.out_pixel), 1);
    // cursor on a blank pixel
    cycle(mk(8'h31, 4'd4, 4'd0, 12'hABC, 12'h321, 1'b0, 1'b1), 1'b0);
    idle(2);
    check("cursor_blank_pixel", 32'(pif.out_pixel), 1);
    check("cursor_blank_rgb", 32'(pif.out_rgb), 32'hABC);

    // bubbles 1,0,1,1,0
    vpat[0] = 5'b10110;
    for (int i = 4; i >= 0; i--) begin
      r = mk(8'h20, 4'(i), 4'd5, 12'h0FF, 12'hF0F, 1'b0, 1'b0);
      r.v = vpat[0][i];
      cycle(r, 1'b0);
    end
    idle(3);

    // randomized traffic with random frame ticks
    for (int i = 0; i < 400; i++) begin
      r = mk(8'($urandom), 4'($urandom), 4'($urandom), 12'($urandom), 12'($urandom),
             1'($urandom), 1'($urandom_range(0, 3) == 0));
      r.v = ($urandom_range(0, 3) != 0);
      cycle(r, $urandom_range(0, 5) == 0);
    end

    // reset with requests in flight
    cycle(mk(8'h41, 4'd0, 4'd3, 12'hFFF, 12'h000, 1'b0, 1'b0), 1'b1);
    cycle(mk(8'h20, 4'd0, 4'd5, 12'hF00, 12'h00F, 1'b0, 1'b0), 1'b1);
    rst_n = 1'b0;
    drive('0, 1'b0);
    #1;
    check("mid_rst_out_valid", 32'(pif.out_valid), 0);
    check("mid_rst_out_pixel", 32'(pif.out_pixel), 0);
    check("mid_rst_out_rgb", 32'(pif.out_rgb), 0);
    check("mid_rst_rom_en", 32'(rom_en), 0);
    check("mid_rst_rom_addr", 32'(rom_addr), 0);
    check("mid_rst_blink_phase", 32'(blink_phase), 0);
    h1 = '0;
    h2 = '0;
    ticks = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(mk(8'h41, 4'd0, 4'd3, 12'hFFF, 12'h000, 1'b0, 1'b0), 1'b0);
    check("post_rst_no_valid", 32'(pif.out_valid), 0);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/char_pipe.md
CHAR_PIPE -- requirements
Module: char_pipe

Interface
REQ-001 SHALL have parameter GW, default 16, glyph width in pixels (1..32); XW = clog2(GW), minimum 1.
REQ-002 SHALL have parameter GH, default 16, glyph height in rows (1..32); YW = clog2(GH), minimum 1.
REQ-003 SHALL have parameter CW, default 8, character code width.
REQ-004 SHALL have parameter COLW, default 12, colour width (4:4:4 RGB).
REQ-005 SHALL have parameter BLINK_FRAMES, default 32, frame_tick pulses per blink half-period (>=1).
REQ-006 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have ports in_valid  input  1  and in_code  input  CW: pixel request strobe and character code.
REQ-009 SHALL have ports in_x  input  XW  and in_y  input  YW: column and row inside the glyph cell.
REQ-010 SHALL have ports in_fg  input  COLW  and in_bg  input  COLW: foreground and background colour.
REQ-011 SHALL have ports in_blink  input  1  and in_cursor  input  1: blink attribute and cursor-inversion flag.
REQ-012 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-013 SHALL have ports rom_en  output  1  and rom_addr  output  CW+YW  = {code,y}: glyph ROM read request.
REQ-014 SHALL have port rom_data  input  GW  glyph row; synchronous ROM, valid one edge after rom_addr/rom_en.
REQ-015 SHALL have ports out_valid  output  1,  out_pixel  output  1,  out_rgb  output  COLW.
REQ-016 SHALL have port blink_phase  output  1  current blink phase.

Function
REQ-017 At edge E0 SHALL register rom_addr <= {in_code,in_y} and rom_en <= in_valid, and capture side-band (valid,x,fg,bg,blink,cursor) into stage 1.
REQ-018 At edge E1 SHALL move stage-1 side-band to stage 2; ROM drives rom_data for that request after E1.
REQ-019 At edge E2 SHALL register out_valid, out_pixel, out_rgb; latency in_valid -> out_valid fixed at 3 edges; throughput one pixel per clock, no backpressure.
REQ-020 Glyph bit SHALL be rom_data[GW-1-x] (MSB = leftmost pixel); x >= GW SHALL yield glyph bit 0.
REQ-021 Blink: if stage-2 blink=1 and blink_phase=1 at E2, glyph bit SHALL be forced 0.
REQ-022 Cursor: if stage-2 cursor=1, bit SHALL be inverted after the blink step (cursor visible during blink-off).
REQ-023 out_pixel SHALL be the final bit; out_rgb SHALL be fg when bit=1, else bg.
REQ-024 When stage-2 valid=0 at E2, out_valid, out_pixel, out_rgb SHALL all register 0.
REQ-025 Blink counter SHALL increment on frame_tick; on tick at count BLINK_FRAMES-1 it SHALL wrap to 0 and toggle blink_phase; BLINK_FRAMES=1 toggles every tick.
REQ-026 frame_tick SHALL be independent of the pixel pipeline; a toggle at edge E2 SHALL NOT affect the pixel registered at that same edge (old phase used).
REQ-027 Gaps in in_valid SHALL produce matching out_valid gaps, with no reordering or merging.

Reset
REQ-028 rst_n low SHALL immediately clear rom_en, rom_addr, all stage valids/side-band, out_valid, out_pixel, out_rgb, blink counter and blink_phase to 0.
REQ-029 Reset mid-operation SHALL discard in-flight requests; first out_valid after release occurs no earlier than 3 edges after the first accepted in_valid.
REQ-030 Deassertion SHALL be synchronised externally; block SHALL accept in_valid on the first edge after rst_n high.

Verification
REQ-031 Single pixel: code=0x41,y=3,x=0,fg=0xFFF,bg=0x000, rom_data=0x8000 -> rom_addr=0x413 after E0; out_valid=1,out_pixel=1,out_rgb=0xFFF after E2 only.
REQ-032 Streaming x=0..15 over row rom_data=0xA5A5, fg=0xF00,bg=0x00F -> 16 consecutive valid outputs, pixels 1010010110100101, colours match.
REQ-033 Blink: BLINK_FRAMES=2, blink=1, lit pixel; 2 frame_ticks -> blink_phase=1, out_pixel=0,out_rgb=bg; 2 more ticks -> restored.
REQ-034 Cursor: cursor=1 on blank pixel -> out_pixel=1,out_rgb=fg; cursor=1,blink=1,phase=1 on lit pixel -> out_pixel=1.
REQ-035 Reset: assert rst_n low with 2 requests in flight -> all outputs 0 immediately, no out_valid for discarded requests after release.
REQ-036 Bubble pattern in_valid=1,0,1,1,0 -> out_valid=1,0,1,1,0 delayed 3 edges, invalid slots with out_rgb=0.
